// File: rtl/rv_pipe_pkg.sv
// Shared definitions for the decode->execute pipeline register.
// Holds the default datapath widths, the bit layout of the packed control
// bundle, a struct view of the full payload and a helper that packs the
// individual control fields into the bundle.
package rv_pipe_pkg;

  localparam int DEF_XLEN   = 32;
  localparam int DEF_REG_AW = 5;
  localparam int CTRL_W     = 16;

  // Control bundle layout, LSB first.
  localparam int CTRL_ALUCONTROL_LSB = 0;   // 6 bits
  localparam int CTRL_ALUSRC_LSB     = 6;   // 1 bit
  localparam int CTRL_BRANCH_LSB     = 7;   // 1 bit
  localparam int CTRL_JUMP_LSB       = 8;   // 1 bit
  localparam int CTRL_MEMWRITE_LSB   = 9;   // 2 bits
  localparam int CTRL_RESULTSRC_LSB  = 11;  // 2 bits
  localparam int CTRL_REGWRITE_LSB   = 13;  // 3 bits

  // Payload at the default widths; field order matches the packing used in the top.
  typedef struct packed {
    logic [CTRL_W-1:0]     ctrl;
    logic [DEF_XLEN-1:0]   rd1;
    logic [DEF_XLEN-1:0]   rd2;
    logic [DEF_XLEN-1:0]   imm;
    logic [DEF_XLEN-1:0]   pc;
    logic [DEF_XLEN-1:0]   pc4;
    logic [DEF_REG_AW-1:0] rs1;
    logic [DEF_REG_AW-1:0] rs2;
    logic [DEF_REG_AW-1:0] rd;
  } id_ex_payload_t;

  function automatic logic [CTRL_W-1:0] ctrl_pack(
    input logic [2:0] reg_write,
    input logic [1:0] result_src,
    input logic [1:0] mem_write,
    input logic       jump,
    input logic       branch,
    input logic       alu_src,
    input logic [5:0] alu_control
  );
    logic [CTRL_W-1:0] c;
    c = {CTRL_W{1'b0}};
    c[CTRL_REGWRITE_LSB +: 3]   = reg_write;
    c[CTRL_RESULTSRC_LSB +: 2]  = result_src;
    c[CTRL_MEMWRITE_LSB +: 2]   = mem_write;
    c[CTRL_JUMP_LSB]            = jump;
    c[CTRL_BRANCH_LSB]          = branch;
    c[CTRL_ALUSRC_LSB]          = alu_src;
    c[CTRL_ALUCONTROL_LSB +: 6] = alu_control;
    return c;
  endfunction

endpackage

// File: rtl/id_ex_pipe_reg_if.sv
// Handshake and payload bundle between decode, the ID/EX register and execute.
// master: environment side (drives in_*, flush, out_ready).
// slave : the pipeline register (drives in_ready, out_*, haz_*, bubble_cnt).
interface id_ex_pipe_reg_if #(
  parameter int XLEN   = rv_pipe_pkg::DEF_XLEN,
  parameter int REG_AW = rv_pipe_pkg::DEF_REG_AW,
  parameter int CTRL_W = rv_pipe_pkg::CTRL_W,
  parameter int CNT_W  = 16
);
  logic              flush;
  logic              in_valid;
  logic              in_ready;
  logic [CTRL_W-1:0] in_ctrl;
  logic [XLEN-1:0]   in_rd1;
  logic [XLEN-1:0]   in_rd2;
  logic [XLEN-1:0]   in_imm;
  logic [XLEN-1:0]   in_pc;
  logic [XLEN-1:0]   in_pc4;
  logic [REG_AW-1:0] in_rs1;
  logic [REG_AW-1:0] in_rs2;
  logic [REG_AW-1:0] in_rd;
  logic              out_valid;
  logic              out_ready;
  logic [CTRL_W-1:0] out_ctrl;
  logic [XLEN-1:0]   out_rd1;
  logic [XLEN-1:0]   out_rd2;
  logic [XLEN-1:0]   out_imm;
  logic [XLEN-1:0]   out_pc;
  logic [XLEN-1:0]   out_pc4;
  logic [REG_AW-1:0] out_rs1;
  logic [REG_AW-1:0] out_rs2;
  logic [REG_AW-1:0] out_rd;
  logic [REG_AW-1:0] haz_rs1;
  logic [REG_AW-1:0] haz_rs2;
  logic [CNT_W-1:0]  bubble_cnt;

  modport master (
    output flush, in_valid, in_ctrl, in_rd1, in_rd2, in_imm, in_pc, in_pc4,
           in_rs1, in_rs2, in_rd, out_ready,
    input  in_ready, out_valid, out_ctrl, out_rd1, out_rd2, out_imm, out_pc,
           out_pc4, out_rs1, out_rs2, out_rd, haz_rs1, haz_rs2, bubble_cnt
  );

  modport slave (
    input  flush, in_valid, in_ctrl, in_rd1, in_rd2, in_imm, in_pc, in_pc4,
           in_rs1, in_rs2, in_rd, out_ready,
    output in_ready, out_valid, out_ctrl, out_rd1, out_rd2, out_imm, out_pc,
           out_pc4, out_rs1, out_rs2, out_rd, haz_rs1, haz_rs2, bubble_cnt
  );
endinterface

// File: rtl/pipe_slot.sv
// One pipeline entry: a valid flag plus a payload register.
// Ports: clk, rst (async active-high), load (capture d, set valid),
//        clear (drop valid; wins over load), d, valid, q.
// The payload only changes on an effective load, so it holds while idle.
module pipe_slot #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic         clear,
  input  logic [W-1:0] d,
  output logic         valid,
  output logic [W-1:0] q
);

  // Valid flag: clear dominates load.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid <= 1'b0;
    end else if (clear) begin
      valid <= 1'b0;
    end else if (load) begin
      valid <= 1'b1;
    end else begin
      valid <= valid;
    end
  end

  // Payload: loads only when the entry is really being filled.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      q <= {W{1'b0}};
    end else if (load && !clear) begin
      q <= d;
    end else begin
      q <= q;
    end
  end

endmodule

// File: rtl/id_ex_pipe_reg.sv
// Decode->execute pipeline register with valid/ready handshake, flush,
// optional skid entry and a saturating bubble counter.
// Ports: clk, rst (async active-high), bus (slave side of id_ex_pipe_reg_if:
//        in_* from decode, out_* to execute, haz_* to the hazard unit,
//        flush, bubble_cnt).
// Main entry M drives the outputs. With SKID_EN=1 a skid entry S catches the
// instruction accepted while execute stalls, making in_ready a flop output.
module id_ex_pipe_reg #(
  parameter int XLEN    = rv_pipe_pkg::DEF_XLEN,
  parameter int REG_AW  = rv_pipe_pkg::DEF_REG_AW,
  parameter int CTRL_W  = rv_pipe_pkg::CTRL_W,
  parameter int SKID_EN = 1,
  parameter int CNT_W   = 16
) (
  input logic            clk,
  input logic            rst,
  id_ex_pipe_reg_if.slave bus
);

  localparam int DAT_W = 5 * XLEN + 3 * REG_AW;
  localparam int PAY_W = CTRL_W + DAT_W;

  logic [PAY_W-1:0]  in_pay_s;
  logic [PAY_W-1:0]  m_src_s;
  logic [PAY_W-1:0]  s_q_s;
  logic [DAT_W-1:0]  m_q_s;
  logic              m_valid_s;
  logic              s_valid_s;
  logic              in_ready_s;
  logic              accept_s;
  logic              consume_s;
  logic              m_from_s;
  logic              m_load_in_s;
  logic              m_load_s;
  logic              m_clear_s;
  logic [CTRL_W-1:0] ctrl_r;
  logic [CNT_W-1:0]  bubble_r;

  assign in_pay_s = {bus.in_ctrl, bus.in_rd1, bus.in_rd2, bus.in_imm, bus.in_pc,
                     bus.in_pc4, bus.in_rs1, bus.in_rs2, bus.in_rd};

  // Flush forces in_ready high so decode never stalls on a killed instruction.
  assign in_ready_s = (SKID_EN != 0) ? (bus.flush | ~s_valid_s)
                                     : (bus.flush | ~m_valid_s | bus.out_ready);

  assign accept_s    = bus.in_valid & in_ready_s;
  assign consume_s   = m_valid_s & bus.out_ready;
  // A held skid instruction always refills M before anything new (FIFO order).
  assign m_from_s    = consume_s & s_valid_s;
  assign m_load_in_s = accept_s & ~s_valid_s & (~m_valid_s | bus.out_ready);
  assign m_load_s    = m_from_s | m_load_in_s;
  assign m_clear_s   = bus.flush | (consume_s & ~m_load_s);
  assign m_src_s     = m_from_s ? s_q_s : in_pay_s;

  // Control lives outside the M slot so it can be cleared to zero on every
  // bubble while the data payload keeps its last value.
  pipe_slot #(.W(DAT_W)) u_main (
    .clk   (clk),
    .rst   (rst),
    .load  (m_load_s),
    .clear (m_clear_s),
    .d     (m_src_s[DAT_W-1:0]),
    .valid (m_valid_s),
    .q     (m_q_s)
  );

  generate
    if (SKID_EN != 0) begin : g_skid
      logic s_load_s;
      logic s_clear_s;
      assign s_load_s  = accept_s & m_valid_s & ~bus.out_ready;
      assign s_clear_s = bus.flush | m_from_s;
      pipe_slot #(.W(PAY_W)) u_skid (
        .clk   (clk),
        .rst   (rst),
        .load  (s_load_s),
        .clear (s_clear_s),
        .d     (in_pay_s),
        .valid (s_valid_s),
        .q     (s_q_s)
      );
    end else begin : g_no_skid
      assign s_valid_s = 1'b0;
      assign s_q_s     = {PAY_W{1'b0}};
    end
  endgenerate

  // Gated control register: nonzero only while M holds a valid instruction.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ctrl_r <= {CTRL_W{1'b0}};
    end else if (m_clear_s) begin
      ctrl_r <= {CTRL_W{1'b0}};
    end else if (m_load_s) begin
      ctrl_r <= m_src_s[PAY_W-1:DAT_W];
    end else begin
      ctrl_r <= ctrl_r;
    end
  end

  // Bubble counter: counts empty output cycles, sticks at all-ones.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bubble_r <= {CNT_W{1'b0}};
    end else if (!m_valid_s && (bubble_r != {CNT_W{1'b1}})) begin
      bubble_r <= bubble_r + {{(CNT_W-1){1'b0}}, 1'b1};
    end else begin
      bubble_r <= bubble_r;
    end
  end

  assign bus.in_ready   = in_ready_s;
  assign bus.out_valid  = m_valid_s;
  assign bus.out_ctrl   = ctrl_r;
  assign bus.bubble_cnt = bubble_r;
  assign {bus.out_rd1, bus.out_rd2, bus.out_imm, bus.out_pc, bus.out_pc4,
          bus.out_rs1, bus.out_rs2, bus.out_rd} = m_q_s;
  assign bus.haz_rs1 = bus.in_valid ? bus.in_rs1 : {REG_AW{1'b0}};
  assign bus.haz_rs2 = bus.in_valid ? bus.in_rs2 : {REG_AW{1'b0}};

endmodule

// File: tb/tb_id_ex_pipe_reg.sv
// Directed bench for id_ex_pipe_reg. Two instances share one stimulus:
// dut_a with a skid entry and a 16-bit counter, dut_b single-entry with a
// 4-bit counter (saturation and combinational in_ready).
module tb_id_ex_pipe_reg;
  import rv_pipe_pkg::*;

  logic clk = 1'b0;
  logic rst;
  logic flush;
  logic in_valid;
  logic out_ready;
  id_ex_payload_t stim;

  int n_chk  = 0;
  int n_pass = 0;

  always #5 clk = ~clk;

  id_ex_pipe_reg_if #(.XLEN(32), .REG_AW(5), .CTRL_W(16), .CNT_W(16)) bus_a ();
  id_ex_pipe_reg_if #(.XLEN(32), .REG_AW(5), .CTRL_W(16), .CNT_W(4))  bus_b ();

  assign bus_a.flush = flush;      assign bus_b.flush = flush;
  assign bus_a.in_valid = in_valid; assign bus_b.in_valid = in_valid;
  assign bus_a.out_ready = out_ready; assign bus_b.out_ready = out_ready;
  assign bus_a.in_ctrl = stim.ctrl; assign bus_b.in_ctrl = stim.ctrl;
  assign bus_a.in_rd1 = stim.rd1;  assign bus_b.in_rd1 = stim.rd1;
  assign bus_a.in_rd2 = stim.rd2;  assign bus_b.in_rd2 = stim.rd2;
  assign bus_a.in_imm = stim.imm;  assign bus_b.in_imm = stim.imm;
  assign bus_a.in_pc = stim.pc;    assign bus_b.in_pc = stim.pc;
  assign bus_a.in_pc4 = stim.pc4;  assign bus_b.in_pc4 = stim.pc4;
  assign bus_a.in_rs1 = stim.rs1;  assign bus_b.in_rs1 = stim.rs1;
  assign bus_a.in_rs2 = stim.rs2;  assign bus_b.in_rs2 = stim.rs2;
  assign bus_a.in_rd = stim.rd;    assign bus_b.in_rd = stim.rd;

  id_ex_pipe_reg #(.XLEN(32), .REG_AW(5), .CTRL_W(16), .SKID_EN(1), .CNT_W(16)) dut_a (
    .clk (clk), .rst (rst), .bus (bus_a)
  );
  id_ex_pipe_reg #(.XLEN(32), .REG_AW(5), .CTRL_W(16), .SKID_EN(0), .CNT_W(4)) dut_b (
    .clk (clk), .rst (rst), .bus (bus_b)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end else begin
      n_pass++;
    end
  endtask

  function automatic logic [15:0] ctrl_of(input logic [31:0] pc);
    return ctrl_pack(3'b001, 2'b01, 2'b00, 1'b0, 1'b0, 1'b1, pc[7:2]);
  endfunction

  task automatic set_in(input logic v, input logic [31:0] pc, input logic [15:0] ctrl,
                        input logic [31:0] rd1);
    in_valid  = v;
    stim.ctrl = ctrl;
    stim.rd1  = rd1;
    stim.rd2  = ~pc;
    stim.imm  = pc << 1;
    stim.pc   = pc;
    stim.pc4  = pc + 32'd4;
    stim.rs1  = pc[6:2] + 5'd1;
    stim.rs2  = pc[6:2] ^ 5'h1F;
    stim.rd   = pc[6:2];
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1;
    flush = 1'b0;
    out_ready = 1'b0;
    set_in(1'b1, 32'h40, ctrl_of(32'h40), 32'h1111);

    // 1. Reset with a valid input present.
    tick();
    tick();
    check("rst_a_valid", bus_a.out_valid, 64'd0);
    check("rst_a_ctrl", bus_a.out_ctrl, 64'd0);
    check("rst_a_pc", bus_a.out_pc, 64'd0);
    check("rst_a_bubble", bus_a.bubble_cnt, 64'd0);
    check("rst_a_ready", bus_a.in_ready, 64'd1);
    check("rst_b_ready", bus_b.in_ready, 64'd1);
    check("rst_haz_rs1", bus_a.haz_rs1, 64'd17);
    rst = 1'b0;
    set_in(1'b0, 32'h40, ctrl_of(32'h40), 32'h1111);
    repeat (5) tick();
    check("idle_a_bubble", bus_a.bubble_cnt, 64'd5);
    check("idle_b_bubble", bus_b.bubble_cnt, 64'd5);
    check("idle_haz_rs1", bus_a.haz_rs1, 64'd0);

    // 2. Streaming with execute always ready.
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      set_in(1'b1, 32'(4 * i), ctrl_of(32'(4 * i)), 32'h100 + 32'(i));
      tick();
      check("stream_a_valid", bus_a.out_valid, 64'd1);
      check("stream_a_pc", bus_a.out_pc, 64'(4 * i));
      check("stream_a_ctrl", bus_a.out_ctrl, 64'(ctrl_of(32'(4 * i))));
      check("stream_b_pc", bus_b.out_pc, 64'(4 * i));
    end
    check("stream_a_rd1", bus_a.out_rd1, 64'h103);
    check("stream_a_pc4", bus_a.out_pc4, 64'd16);
    set_in(1'b0, 32'h0, 16'h0000, 32'h0);
    tick();
    check("stream_a_drain", bus_a.out_valid, 64'd0);
    check("stream_b_drain", bus_b.out_valid, 64'd0);
    check("stream_a_bubble", bus_a.bubble_cnt, 64'd6);
    check("stream_b_bubble", bus_b.bubble_cnt, 64'd6);

    // 3. Backpressure.
    out_ready = 1'b0;
    set_in(1'b1, 32'h0, ctrl_of(32'h0), 32'h200);
    tick();
    check("bp_a_pc0", bus_a.out_pc, 64'd0);
    check("bp_a_ready_empty_s", bus_a.in_ready, 64'd1);
    set_in(1'b1, 32'h4, ctrl_of(32'h4), 32'h204);
    #1;
    check("bp_b_ready_stall", bus_b.in_ready, 64'd0);
    tick();
    check("bp_a_ready_full_s", bus_a.in_ready, 64'd0);
    check("bp_a_hold_pc", bus_a.out_pc, 64'd0);
    check("bp_b_hold_pc", bus_b.out_pc, 64'd0);
    out_ready = 1'b1;
    #1;
    check("bp_b_ready_go", bus_b.in_ready, 64'd1);
    check("bp_a_ready_still", bus_a.in_ready, 64'd0);
    tick();
    check("bp_a_pc4", bus_a.out_pc, 64'd4);
    check("bp_a_rd1", bus_a.out_rd1, 64'h204);
    check("bp_a_ready_back", bus_a.in_ready, 64'd1);
    check("bp_b_pc4", bus_b.out_pc, 64'd4);
    set_in(1'b1, 32'h8, ctrl_of(32'h8), 32'h208);
    tick();
    check("bp_a_pc8", bus_a.out_pc, 64'd8);
    out_ready = 1'b0;
    set_in(1'b1, 32'hC, ctrl_of(32'hC), 32'h20C);
    tick();
    check("bp_a_pc8_held", bus_a.out_pc, 64'd8);
    check("bp_a_s_full", bus_a.in_ready, 64'd0);
    check("bp_b_pc8_held", bus_b.out_pc, 64'd8);

    // 4. Flush with M=8, S=12 and pc 16 on the input.
    flush = 1'b1;
    set_in(1'b1, 32'h10, ctrl_of(32'h10), 32'h210);
    #1;
    check("fl_a_ready_forced", bus_a.in_ready, 64'd1);
    check("fl_b_ready_forced", bus_b.in_ready, 64'd1);
    tick();
    flush = 1'b0;
    set_in(1'b0, 32'h0, 16'h0000, 32'h0);
    out_ready = 1'b1;
    check("fl_a_valid", bus_a.out_valid, 64'd0);
    check("fl_a_ctrl", bus_a.out_ctrl, 64'd0);
    check("fl_b_valid", bus_b.out_valid, 64'd0);
    check("fl_b_ctrl", bus_b.out_ctrl, 64'd0);
    check("fl_a_ready", bus_a.in_ready, 64'd1);
    tick();
    tick();
    check("fl_a_no_ghost", bus_a.out_valid, 64'd0);
    check("fl_b_no_ghost", bus_b.out_valid, 64'd0);
    check("fl_a_bubble", bus_a.bubble_cnt, 64'd9);
    check("fl_b_bubble", bus_b.bubble_cnt, 64'd9);

    // 5. Control gating while the payload holds.
    set_in(1'b1, 32'h20, 16'hFFFF, 32'hDEADBEEF);
    tick();
    check("gate_a_ctrl_on", bus_a.out_ctrl, 64'hFFFF);
    check("gate_b_ctrl_on", bus_b.out_ctrl, 64'hFFFF);
    set_in(1'b0, 32'h24, ctrl_of(32'h24), 32'h0);
    tick();
    check("gate_a_ctrl_off", bus_a.out_ctrl, 64'd0);
    check("gate_b_ctrl_off", bus_b.out_ctrl, 64'd0);
    check("gate_a_rd1_hold", bus_a.out_rd1, 64'hDEADBEEF);
    check("gate_b_rd1_hold", bus_b.out_rd1, 64'hDEADBEEF);
    check("gate_a_bubble", bus_a.bubble_cnt, 64'd10);

    // 6. Saturation of the 4-bit counter.
    repeat (20) tick();
    check("sat_a_bubble", bus_a.bubble_cnt, 64'd30);
    check("sat_b_bubble", bus_b.bubble_cnt, 64'd15);
    tick();
    check("sat_a_bubble2", bus_a.bubble_cnt, 64'd31);
    check("sat_b_stays", bus_b.bubble_cnt, 64'd15);

    // Reset in the middle of a stalled handshake discards both entries.
    out_ready = 1'b0;
    set_in(1'b1, 32'h30, ctrl_of(32'h30), 32'h330);
    tick();
    set_in(1'b1, 32'h34, ctrl_of(32'h34), 32'h334);
    tick();
    check("mid_a_s_full", bus_a.in_ready, 64'd0);
    #2;
    rst = 1'b1;
    #1;
    check("mid_a_valid", bus_a.out_valid, 64'd0);
    check("mid_a_pc", bus_a.out_pc, 64'd0);
    check("mid_a_ready", bus_a.in_ready, 64'd1);
    check("mid_a_bubble", bus_a.bubble_cnt, 64'd0);
    check("mid_b_pc", bus_b.out_pc, 64'd0);
    tick();
    rst = 1'b0;

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
